// File: rtl/mod_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : mod_operand_loader
// Description : Serial frame loader for a modular add/sub stage. A frame is
//               nine valid/ready bits (s, raw X MSB-first, raw Y MSB-first).
//               Each operand is reduced modulo m and the frame is held on
//               registered outputs until downstream consumes it.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_operand_loader #(
  parameter logic [3:0] m = 4'b1111
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic sin,
  input  logic sin_valid,
  output logic sin_ready,
  output logic s,
  output logic x3,
  output logic x2,
  output logic x1,
  output logic x0,
  output logic y3,
  output logic y2,
  output logic y1,
  output logic y0,
  output logic out_valid,
  input  logic out_ready,
  output logic reduced
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_X  = 2'd1,
    LOAD_Y  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t     r_state;
  logic [1:0] r_cnt;
  logic       r_s_cap;
  logic [3:0] r_x_raw;
  logic [2:0] r_y_sh;
  logic       r_s;
  logic [3:0] r_x;
  logic [3:0] r_y;
  logic       r_reduced;
  logic       r_out_valid;
  logic       r_sin_ready;

  logic       w_xfer;
  logic [3:0] w_y_raw;
  logic       w_x_ge;
  logic       w_y_ge;
  logic [3:0] w_x_red;
  logic [3:0] w_y_red;

  // Transfer qualification and single-subtraction reduction (raw <= 15 < 2m).
  // The last Y bit is still on sin at the completing edge, so raw Y is formed
  // from the three shifted bits plus the live input.
  assign w_xfer  = sin_valid & r_sin_ready;
  assign w_y_raw = {r_y_sh, sin};
  assign w_x_ge  = (r_x_raw >= m);
  assign w_y_ge  = (w_y_raw >= m);
  assign w_x_red = w_x_ge ? (r_x_raw - m) : r_x_raw;
  assign w_y_red = w_y_ge ? (w_y_raw - m) : w_y_raw;

  // Frame FSM: shifts in bits, latches the reduced frame and runs the handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_s_cap     <= 1'b0;
      r_x_raw     <= 4'd0;
      r_y_sh      <= 3'd0;
      r_s         <= 1'b0;
      r_x         <= 4'd0;
      r_y         <= 4'd0;
      r_reduced   <= 1'b0;
      r_out_valid <= 1'b0;
      r_sin_ready <= 1'b1;
    end else if (clr) begin
      // Abort wins over any transfer or handshake on the same edge.
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_out_valid <= 1'b0;
      r_sin_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_s_cap <= sin;
            r_cnt   <= 2'd0;
            r_state <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (w_xfer) begin
            r_x_raw <= {r_x_raw[2:0], sin};
            if (r_cnt == 2'd3) begin
              r_cnt   <= 2'd0;
              r_state <= LOAD_Y;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        LOAD_Y: begin
          if (w_xfer) begin
            r_y_sh <= w_y_raw[2:0];
            if (r_cnt == 2'd3) begin
              r_cnt       <= 2'd0;
              r_state     <= PRESENT;
              r_s         <= r_s_cap;
              r_x         <= w_x_red;
              r_y         <= w_y_red;
              r_reduced   <= w_x_ge | w_y_ge;
              r_out_valid <= 1'b1;
              r_sin_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        PRESENT: begin
          // Presented values stay put; only the consuming handshake leaves.
          if (out_ready) begin
            r_cnt       <= 2'd0;
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_sin_ready <= 1'b1;
          end
        end
        default: begin
          r_cnt       <= 2'd0;
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_sin_ready <= 1'b1;
        end
      endcase
    end
  end

  assign sin_ready = r_sin_ready;
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign reduced   = r_reduced;
  assign x3        = r_x[3];
  assign x2        = r_x[2];
  assign x1        = r_x[1];
  assign x0        = r_x[0];
  assign y3        = r_y[3];
  assign y2        = r_y[2];
  assign y1        = r_y[1];
  assign y0        = r_y[0];

endmodule
`default_nettype wire

// File: tb/tb_mod_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_operand_loader
// Description : Self-checking bench; one loader per modulus 9..15 driven by
//               shared stimulus and compared against a modulo reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_operand_loader;

  localparam int c_NINST = 7;

  logic clk;
  logic rst_n;
  logic clr;
  logic sin;
  logic sin_valid;
  logic out_ready;

  logic [c_NINST-1:0]      w_sin_ready;
  logic [c_NINST-1:0]      w_s;
  logic [c_NINST-1:0]      w_out_valid;
  logic [c_NINST-1:0]      w_reduced;
  logic [c_NINST-1:0][3:0] w_x;
  logic [c_NINST-1:0][3:0] w_y;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < c_NINST; gi++) begin : g_dut
    mod_operand_loader #(.m(4'(9 + gi))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .sin       (sin),
      .sin_valid (sin_valid),
      .sin_ready (w_sin_ready[gi]),
      .s         (w_s[gi]),
      .x3        (w_x[gi][3]),
      .x2        (w_x[gi][2]),
      .x1        (w_x[gi][1]),
      .x0        (w_x[gi][0]),
      .y3        (w_y[gi][3]),
      .y2        (w_y[gi][2]),
      .y1        (w_y[gi][1]),
      .y0        (w_y[gi][0]),
      .out_valid (w_out_valid[gi]),
      .out_ready (out_ready),
      .reduced   (w_reduced[gi])
    );
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake state of every instance (they all see the same stimulus).
  task automatic check_hs(input string tag, input int exp_valid, input int exp_ready);
    for (int i = 0; i < c_NINST; i++) begin
      chk($sformatf("%s_valid_m%0d", tag, 9 + i), int'(w_out_valid[i]), exp_valid);
      chk($sformatf("%s_ready_m%0d", tag, 9 + i), int'(w_sin_ready[i]), exp_ready);
    end
  endtask

  // Reference: presented operands are raw mod m; flag if either raw >= m.
  task automatic check_frame(input string tag, input int fs, input int fx, input int fy);
    int mm;
    for (int i = 0; i < c_NINST; i++) begin
      mm = 9 + i;
      chk($sformatf("%s_valid_m%0d", tag, mm), int'(w_out_valid[i]), 1);
      chk($sformatf("%s_ready_m%0d", tag, mm), int'(w_sin_ready[i]), 0);
      chk($sformatf("%s_s_m%0d", tag, mm), int'(w_s[i]), fs);
      chk($sformatf("%s_x_m%0d", tag, mm), int'(w_x[i]), fx % mm);
      chk($sformatf("%s_y_m%0d", tag, mm), int'(w_y[i]), fy % mm);
      chk($sformatf("%s_red_m%0d", tag, mm), int'(w_reduced[i]),
          ((fx >= mm) || (fy >= mm)) ? 1 : 0);
    end
  endtask

  // One bit transfer preceded by up to gmax idle cycles with junk on sin.
  task automatic send_bit(input logic b, input int gmax);
    int gap;
    gap = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
    repeat (gap) begin
      sin_valid = 1'b0;
      sin       = 1'($urandom);
      tick();
    end
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic send_bits(input int fs, input int fx, input int fy, input int nbits, input int gmax);
    logic [8:0] v;
    v = {1'(fs), 4'(fx), 4'(fy)};
    for (int k = 0; k < nbits; k++) send_bit(v[8 - k], gmax);
  endtask

  // Hold the frame with sin_valid noise, then consume it and expect a bubble.
  task automatic consume(input string tag, input int fs, input int fx, input int fy, input int hold);
    repeat (hold) begin
      out_ready = 1'b0;
      sin_valid = 1'($urandom);
      sin       = 1'($urandom);
      tick();
      check_frame({tag, "_hold"}, fs, fx, fy);
    end
    sin_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_hs({tag, "_done"}, 0, 1);
  endtask

  task automatic full_frame(input string tag, input int fs, input int fx, input int fy,
                            input int gmax, input int hold);
    send_bits(fs, fx, fy, 9, gmax);
    check_frame(tag, fs, fx, fy);
    consume(tag, fs, fx, fy, hold);
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();

    // Reset state, including a transfer attempt while reset is still low.
    sin_valid = 1'b1;
    sin       = 1'b1;
    tick();
    sin_valid = 1'b0;
    check_hs("rst", 0, 1);
    for (int i = 0; i < c_NINST; i++) begin
      chk("rst_s", int'(w_s[i]), 0);
      chk("rst_x", int'(w_x[i]), 0);
      chk("rst_y", int'(w_y[i]), 0);
      chk("rst_red", int'(w_reduced[i]), 0);
    end
    rst_n = 1'b1;
    tick();

    // Directed frames: back-to-back with no gaps, then with gaps.
    full_frame("f035", 0, 3, 5, 0, 0);
    full_frame("f1f9", 1, 15, 9, 2, 1);

    // Long hold with sin_valid toggling: frame frozen, no buffering.
    send_bits(0, 15, 0, 9, 0);
    check_frame("hold", 0, 15, 0);
    consume("hold", 0, 15, 0, 5);

    // Abort after six bits with a simultaneous valid bit.
    send_bits(1, 9, 7, 6, 1);
    clr       = 1'b1;
    sin_valid = 1'b1;
    sin       = 1'b1;
    tick();
    clr       = 1'b0;
    sin_valid = 1'b0;
    check_hs("clr", 0, 1);
    full_frame("aclr", 0, 1, 2, 0, 0);

    // Abort of a presented frame while out_ready is also high.
    send_bits(1, 14, 13, 9, 0);
    check_frame("pclr", 1, 14, 13);
    clr       = 1'b1;
    out_ready = 1'b1;
    tick();
    clr       = 1'b0;
    out_ready = 1'b0;
    check_hs("pclr_after", 0, 1);
    full_frame("apclr", 1, 10, 11, 1, 0);

    // Asynchronous reset in the middle of the Y field.
    send_bits(1, 12, 11, 7, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_hs("arst", 0, 1);
    for (int i = 0; i < c_NINST; i++) begin
      chk("arst_s", int'(w_s[i]), 0);
      chk("arst_x", int'(w_x[i]), 0);
      chk("arst_y", int'(w_y[i]), 0);
      chk("arst_red", int'(w_reduced[i]), 0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    full_frame("arel", 0, 6, 15, 0, 0);

    // Exhaustive operand sweep across all moduli, random gaps and holds.
    for (int fs = 0; fs < 2; fs++)
      for (int fx = 0; fx < 16; fx++)
        for (int fy = 0; fy < 16; fy++)
          full_frame("exh", fs, fx, fy, 1, int'($urandom_range(0, 1)));

    // Randomized frames with longer gaps and holds.
    for (int n = 0; n < 40; n++)
      full_frame("rnd", int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 3, int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_operand_loader.md
MOD_OPERAND_LOADER -- requirements
Module: mod_operand_loader

Interface
REQ-001: Parameter m, default 4'b1111, modulus shared with the downstream modular add/sub stage; legal range 4'b1001..4'b1111.
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: clr  input  1  synchronous frame abort, active-high.
REQ-005: sin  input  1  serial data bit.
REQ-006: sin_valid  input  1  sin carries a valid bit this cycle.
REQ-007: sin_ready  output  1  loader accepts a bit this cycle.
REQ-008: s  output  1  operation select to downstream (0 = add, 1 = subtract).
REQ-009: x3, x2, x1, x0  output  1 each  reduced operand X, x3 = MSB.
REQ-010: y3, y2, y1, y0  output  1 each  reduced operand Y, y3 = MSB.
REQ-011: out_valid  output  1  s/x/y hold a complete frame.
REQ-012: out_ready  input  1  downstream consumes the frame.
REQ-013: reduced  output  1  at least one operand of the presented frame was >= m before reduction.

Function
REQ-014: A bit transfers on a rising edge with sin_valid = 1 and sin_ready = 1; no other edge changes the frame shift state.
REQ-015: A frame is 9 transferred bits in order: s, then raw X MSB-first (4 bits), then raw Y MSB-first (4 bits).
REQ-016: FSM states: IDLE (expect s), LOAD_X (4 bits), LOAD_Y (4 bits), PRESENT.
REQ-017: Transitions: IDLE->LOAD_X on the s transfer; LOAD_X->LOAD_Y on the 4th X transfer; LOAD_Y->PRESENT on the 4th Y transfer; PRESENT->IDLE on an edge with out_valid = 1 and out_ready = 1.
REQ-018: The bit counter runs 0..3 within LOAD_X and LOAD_Y and resets to 0 on every state change.
REQ-019: sin_ready = 1 in IDLE, LOAD_X and LOAD_Y; sin_ready = 0 in PRESENT.
REQ-020: out_valid = 1 exactly when the state is PRESENT.
REQ-021: Latency: out_valid rises on the edge that transfers the 9th bit, so it is visible in the following cycle.
REQ-022: Reduction is performed per operand at the completing edge: value = raw - m if raw >= m, else raw. A single subtraction suffices because raw <= 15 < 2m.
REQ-023: Presented x and y always lie in 0..m-1.
REQ-024: reduced = (raw X >= m) OR (raw Y >= m); it updates on the same edge as out_valid.
REQ-025: s, x3..x0, y3..y0 and reduced remain stable throughout PRESENT regardless of sin or sin_valid, until the consuming handshake.
REQ-026: A sin_valid pulse during PRESENT is ignored and is not buffered.
REQ-027: Outputs outside PRESENT retain their last presented values; downstream qualifies them with out_valid only.
REQ-028: clr = 1 forces IDLE and counter = 0 on the next edge from any state, discarding a partial or presented frame; out_valid = 0 the following cycle.
REQ-029: clr takes priority over a simultaneous bit transfer or out handshake on the same edge.
REQ-030: In PRESENT with out_ready = 1, the frame is consumed on that edge and sin_ready = 1 the next cycle (one-cycle bubble between frames).

Reset
REQ-031: rst_n = 0 asynchronously forces: state IDLE, counter 0, s = 0, x3..x0 = 0000, y3..y0 = 0000, reduced = 0, out_valid = 0, sin_ready = 1.
REQ-032: Reset asserted mid-frame discards all partial bits; the first transfer after release is treated as s.
REQ-033: No transfer occurs on the edge coinciding with rst_n deassertion if rst_n is still low at that edge.

Verification
REQ-034: m = 15; bits 0,0011,0101 -> after 9th edge: out_valid = 1, s = 0, x = 3, y = 5, reduced = 0.
REQ-035: m = 9; bits 1,1111,1001 -> s = 1, x = 6, y = 0, reduced = 1.
REQ-036: m = 15; frame 0,1111,0000 with out_ready = 0 for 5 cycles and sin_valid toggling -> outputs frozen at x = 0, y = 0, reduced = 1, sin_ready = 0; after out_ready = 1: IDLE, sin_ready = 1 next cycle.
REQ-037: Feed 6 bits, assert clr with sin_valid = 1 -> IDLE, counter 0; next 9-bit frame 0,0001,0010 presents x = 1, y = 2.
REQ-038: rst_n low mid-LOAD_Y -> immediate out_valid = 0, all outputs 0; a following full frame loads correctly.
REQ-039: Exhaustive check for each m in 9..15 over s in 0..1 and raw x, y in 0..15: presented values equal raw mod m, and reduced matches.
